// File: rtl/cpu_pkg.sv
// Shared types for the ARM-lite pipeline control: forwarding selects, the
// per-stage shadow control record, and the register-writer predicate.
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rn;
        logic [REG_IDX_W-1:0] rm;
        logic                 uses_rn;
        logic                 uses_rm;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwri;
        logic                 readmem;
        logic                 enflags;
    } shadow_ctrl_t;

    localparam shadow_ctrl_t SHADOW_EMPTY = '0;

    // The zero register is never a real destination, so it never creates a dependency.
    function automatic logic is_writer(input shadow_ctrl_t s,
                                       input logic [REG_IDX_W-1:0] r,
                                       input logic [REG_IDX_W-1:0] xzr);
        return s.valid & s.regwri & (s.rd == r) & (r != xzr);
    endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Operand forwarding select for one EX source: the youngest non-load writer wins.
import cpu_pkg::*;

module hazard_fwd_mux_sel #(
    parameter logic [REG_IDX_W-1:0] XZR = XZR_IDX
) (
    input  logic                 ex_valid,
    input  logic                 ex_uses,
    input  logic [REG_IDX_W-1:0] ex_src,
    input  shadow_ctrl_t         mem_stage,
    input  shadow_ctrl_t         wb_stage,
    output fwd_sel_e             sel
);

    logic needs_src;
    logic mem_hit;
    logic wb_hit;

    assign needs_src = ex_valid & ex_uses;
    // A load in MEM has no data yet; the load-use stall pushes it to WB first.
    assign mem_hit   = is_writer(mem_stage, ex_src, XZR) & ~mem_stage.readmem;
    assign wb_hit    = is_writer(wb_stage, ex_src, XZR);

    always_comb begin
        sel = FWD_RF;
        if (needs_src) begin
            if (mem_hit) begin
                sel = FWD_MEM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadows decoded control through EX/MEM/WB and
// derives forwarding selects, load-use and flag stalls, branch flushes and a stall counter.
import cpu_pkg::*;

module hazard_unit #(
    parameter int REG_W = REG_IDX_W,
    parameter int XZR   = 31,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwri,
    input  logic             id_readmem,
    input  logic             id_enflags,
    input  logic             id_bcond,
    input  logic             ex_brtaken,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_IDX_W-1:0] XZR_R = REG_IDX_W'(XZR);
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    shadow_ctrl_t     id_ctrl;
    shadow_ctrl_t     ex_q;
    shadow_ctrl_t     mem_q;
    shadow_ctrl_t     wb_q;
    logic [CNT_W-1:0] cnt_q;

    logic     load_use;
    logic     flag_use;
    logic     flush_int;
    logic     stall_int;
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    always_comb begin
        id_ctrl         = SHADOW_EMPTY;
        id_ctrl.valid   = id_valid;
        id_ctrl.rn      = id_rn;
        id_ctrl.rm      = id_rm;
        id_ctrl.uses_rn = id_uses_rn;
        id_ctrl.uses_rm = id_uses_rm;
        id_ctrl.rd      = id_rd;
        id_ctrl.regwri  = id_regwri;
        id_ctrl.readmem = id_readmem;
        id_ctrl.enflags = id_enflags;
    end

    assign load_use = id_valid & ex_q.readmem &
                      ((id_uses_rn & is_writer(ex_q, id_rn, XZR_R)) |
                       (id_uses_rm & is_writer(ex_q, id_rm, XZR_R)));

    // No flag forwarding: a B.cond waits one cycle behind a flag setter.
    assign flag_use = id_valid & id_bcond & ex_q.valid & ex_q.enflags;

    // A taken branch discards the ID instruction, so any stall it wanted is moot.
    assign flush_int = reset_n & ex_brtaken;
    assign stall_int = reset_n & ~ex_brtaken & (load_use | flag_use);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q  <= SHADOW_EMPTY;
            mem_q <= SHADOW_EMPTY;
            wb_q  <= SHADOW_EMPTY;
            cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            // Bubbles are fully cleared records so they never match as writers or readers.
            if (stall_int || flush_int || !id_valid) begin
                ex_q <= SHADOW_EMPTY;
            end else begin
                ex_q <= id_ctrl;
            end
            if (stall_int && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    hazard_fwd_mux_sel #(.XZR(XZR_R)) u_fwd_a (
        .ex_valid  (ex_q.valid),
        .ex_uses   (ex_q.uses_rn),
        .ex_src    (ex_q.rn),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (sel_a)
    );

    hazard_fwd_mux_sel #(.XZR(XZR_R)) u_fwd_b (
        .ex_valid  (ex_q.valid),
        .ex_uses   (ex_q.uses_rm),
        .ex_src    (ex_q.rm),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (sel_b)
    );

    assign stall       = stall_int;
    assign flush_ifid  = flush_int;
    assign flush_idex  = flush_int;
    assign fwd_a       = reset_n ? sel_a : FWD_RF;
    assign fwd_b       = reset_n ? sel_b : FWD_RF;
    assign stall_count = reset_n ? cnt_q : '0;

endmodule
